mat_mul_seq: RTL and testbench



---
 rtl/mat_mul_seq.sv | 125 ++++++++++++
 tb/tb_mat_mul_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mul_seq.sv
// mat_mul_seq: streams A and B into a mat_mul datapath, launches it,
// waits for done under a timeout guard and streams C back out.
module mat_mul_seq #(
  parameter int width   = 32,
  parameter int n       = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [width-1:0]     out_data,
  output logic                 out_last,
  output logic                 mm_start,
  output logic [n*n*width-1:0] mm_a,
  output logic [n*n*width-1:0] mm_b,
  input  logic [n*n*width-1:0] mm_c,
  input  logic                 mm_done,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 clr_err
);

  localparam int NN = n * n;
  localparam int IW = $clog2(2 * NN);
  localparam int KW = (NN > 1) ? $clog2(NN) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT, UNLOAD
  } state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [KW-1:0]       k;
  logic [KW-1:0]       kn;
  logic [WW-1:0]       wcnt;
  logic [NN*width-1:0] res;
  logic                take;

  assign take = in_valid & in_ready;
  assign busy = (state != IDLE);
  assign kn   = k + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      k           <= '0;
      wcnt        <= '0;
      res         <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      mm_start    <= 1'b0;
      mm_a        <= '0;
      mm_b        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (clr_err) timeout_err <= 1'b0;
      mm_start <= 1'b0;
      unique case (state)
        IDLE, LOAD: begin
          in_ready <= 1'b1;
          if (take) begin
            if (idx < IW'(NN))
              mm_a[int'(idx)*width +: width] <= in_data;
            else
              mm_b[int'(idx - IW'(NN))*width +: width] <= in_data;
            if (idx == IW'(2 * NN - 1)) begin
              idx      <= '0;
              in_ready <= 1'b0;
              mm_start <= 1'b1;
              state    <= START;
            end else begin
              idx   <= idx + 1'b1;
              state <= LOAD;
            end
          end
        end
        START: begin
          wcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // done seen in the first two wait cycles may be left over
          if (wcnt >= WW'(2) && mm_done) begin
            res       <= mm_c;
            out_valid <= 1'b1;
            out_data  <= mm_c[width-1:0];
            out_last  <= (NN == 1);
            k         <= '0;
            state     <= UNLOAD;
          end else if (wcnt == WW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            in_ready    <= 1'b1;
            state       <= IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end else begin
              k        <= kn;
              out_data <= res[int'(kn)*width +: width];
              out_last <= (kn == KW'(NN - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_mul_seq.sv
// Randomized bench for mat_mul_seq with a stub datapath and a
// matrix-level reference model of the expected C stream.
module tb_mat_mul_seq;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int NN = N * N;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            out_last;
  logic            mm_start;
  logic [NN*W-1:0] mm_a;
  logic [NN*W-1:0] mm_b;
  logic [NN*W-1:0] mm_c;
  logic            mm_done;
  logic            busy;
  logic            timeout_err;
  logic            clr_err;

  always #5 clk = ~clk;

  mat_mul_seq #(.width(W), .n(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
    .mm_c(mm_c), .mm_done(mm_done),
    .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  function automatic logic [NN*W-1:0] dp_mul(
    input logic [NN*W-1:0] a, input logic [NN*W-1:0] b);
    logic [W-1:0] acc;
    dp_mul = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int q = 0; q < N; q++)
          acc += a[(i*N+q)*W +: W] * b[(q*N+j)*W +: W];
        dp_mul[(i*N+j)*W +: W] = acc;
      end
  endfunction

  always_comb mm_c = dp_mul(mm_a, mm_b);

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] ja[NN];
  logic [W-1:0] jb[NN];
  int s_cyc = 0, nstart = 0, hs_cnt = 0, jobs_out = 0;
  int err_cyc = -1, last_hs = 0, ek = 0, rtick = 0;
  int dmode = 0, dlat = 4, rmode = 0;
  bit started = 0, first_seen = 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @cyc %0d", tag, got, want, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // sample just after the falling edge; also drive done and out_ready
  always begin
    @(negedge clk);
    #1;
    if (in_valid && in_ready) hs_cnt++;
    if (mm_start) begin
      nstart++;
      s_cyc = cyc;
      started = 1;
      first_seen = 0;
    end
    if (timeout_err && err_cyc < 0) err_cyc = cyc;
    if (out_valid) begin
      if (!first_seen) begin
        first_seen = 1;
        started = 0;
        chk("first_out_lat", cyc, s_cyc + (dlat > 3 ? dlat : 3) + 1);
      end
      if (exp_q.size() == 0) begin
        chk("spurious_out", out_valid, 1'b0);
      end else begin
        chk("out_data", out_data, exp_q[0]);
        chk("out_last", out_last, ek == NN - 1);
        case (rmode)
          0: out_ready = 1'b1;
          1: out_ready = (rtick % 4 == 0) || (rtick % 4 == 3);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        rtick++;
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (ek == NN - 1) begin
            ek = 0;
            jobs_out++;
          end else ek++;
        end
      end
    end
    case (dmode)
      1: mm_done = 1'b1;
      2: mm_done = 1'b0;
      default: mm_done = started && (cyc - s_cyc >= dlat);
    endcase
  end

  task automatic send(input logic [W-1:0] d, input int gap,
                      output int waited);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    waited   = 0;
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) chk("in_ready_wait", 0, 1);
    last_hs = cyc + 1;
  endtask

  task automatic job(input int gap, input int dm, input int dl,
                     input int rm, input bit b2b, input bit next_b2b);
    logic [W-1:0] ma[N][N];
    logic [W-1:0] mb[N][N];
    logic [W-1:0] rc;
    int h0, n0, j0, w, g;
    dmode = dm; dlat = dl; rmode = rm; rtick = 0; err_cyc = -1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = ja[i*N+j];
        mb[i][j] = jb[i*N+j];
      end
    if (dm != 2)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          rc = '0;
          for (int q = 0; q < N; q++) rc += ma[i][q] * mb[q][j];
          exp_q.push_back(rc);
        end
    h0 = hs_cnt; n0 = nstart; j0 = jobs_out;
    for (int e = 0; e < 2 * NN; e++) begin
      send(e < NN ? ja[e] : jb[e-NN],
           gap < 0 ? $urandom_range(0, 2) : gap, w);
      if (e == 0 && b2b) chk("b2b_accept_wait", w, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    chk("start_cyc", s_cyc, last_hs);
    if (dm == 2) begin
      g = 0;
      while (busy && g < 60) begin
        @(negedge clk); #2; g++;
      end
      chk("to_busy", busy, 0);
      chk("to_err", timeout_err, 1);
      chk("to_cyc", err_cyc, s_cyc + TO + 1);
      chk("to_no_out", jobs_out, j0);
      @(negedge clk); clr_err = 1'b1;
      @(negedge clk); clr_err = 1'b0; #2;
      chk("clr_err", timeout_err, 0);
    end else begin
      g = 0;
      while (jobs_out == j0 && g < 300) begin
        @(negedge clk); #2; g++;
      end
      chk("job_done", jobs_out, j0 + 1);
      if (!next_b2b) begin
        @(negedge clk); #2;
        chk("busy_idle", busy, 0);
        chk("ov_idle", out_valid, 0);
      end
    end
    chk("hs_count", hs_cnt - h0, 2 * NN);
    chk("start_pulses", nstart - n0, 1);
  endtask

  task automatic rand_mats();
    for (int e = 0; e < NN; e++) begin
      ja[e] = $urandom;
      jb[e] = $urandom;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; clr_err = 1'b0; mm_done = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mm_a", mm_a, 0);
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b0;

    for (int e = 0; e < NN; e++) begin
      ja[e] = e + 1;
      jb[e] = (e % (N + 1) == 0) ? 1 : 0;
    end
    job(0, 0, 4, 0, 0, 0);

    for (int e = 0; e < NN; e++) begin
      ja[e] = e + 1;
      jb[e] = NN - e;
    end
    job(0, 0, 1, 0, 0, 0);
    job(1, 0, 6, 1, 0, 0);
    job(0, 1, 0, 2, 0, 0);
    rand_mats();
    job(0, 2, 0, 0, 0, 0);

    rand_mats();
    for (int e = 0; e < 5; e++) send(ja[e], 0, w);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mm_a", mm_a, 0);
    chk("mid_rst_mm_b", mm_b, 0);
    chk("mid_rst_out", {out_valid, out_last, mm_start}, 0);
    chk("mid_rst_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    job(0, 0, 3, 0, 0, 0);

    rand_mats();
    job(0, 0, 5, 0, 0, 1);
    rand_mats();
    job(0, 0, 2, 0, 1, 0);

    for (int r = 0; r < 6; r++) begin
      rand_mats();
      job(-1, 0, $urandom_range(1, 10), 2, 0, 0);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
